rect_fill_engine: RTL and testbench
===================================

# rect_fill_engine

Initiator side of the start/limit/counting handshake used by the VGA test path. Accepts a rectangle-fill request, programs and starts the external 17-bit index counter, and decodes each index it streams back into VGA-adapter plot writes (x, y, colour, plot). Sits between the test-pattern control logic and the VGA adapter, with the counter as its sequencing slave.

## Interface
- `X_W`, 8: x coordinate width
- `Y_W`, 7: y coordinate width
- `COLOR_W`, 3: colour width
- `CNT_W`, 17: counter index/limit width
- `SCREEN_W`, 160: pixels with x ≥ SCREEN_W are clipped
- `SCREEN_H`, 120: pixels with y ≥ SCREEN_H are clipped

- `clk` in 1: single clock, all logic on posedge
- `resetn` in 1: reset, asynchronous, active-low
- `req_valid` in 1: request present
- `req_ready` out 1: engine can accept
- `req_x0` in X_W, `req_y0` in Y_W: top-left corner
- `req_w` in X_W, `req_h` in Y_W: width and height in pixels
- `req_color` in COLOR_W: fill colour
- `cnt_start` out 1: one-cycle start pulse to counter
- `cnt_limit` out CNT_W: index count, w*h
- `cnt_counting` in 1: counter busy
- `cnt_result` in CNT_W: current counter index
- `vga_x` out X_W, `vga_y` out Y_W, `vga_colour` out COLOR_W, `vga_plot` out 1: adapter write port
- `done` out 1: one-cycle completion pulse
- `seq_err` out 1: sticky sequencing error, cleared on next accept

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE: `req_ready = ~cnt_counting`. Accept on `req_valid & req_ready`. On accept, latch x0/y0/w/h/colour, clear `seq_err`, and compute `cnt_limit = w*h` (zero-extended unsigned product, max 32385, never wraps).
- From IDLE on accept: w==0 or h==0 → DONE with no start or plots. Otherwise → START.
- START: `cnt_start=1` for exactly one cycle. Reset walker col=0, row=0, idx=0. → RUN.
- RUN, each cycle with `cnt_counting=1`:
  - Emit one pixel at (x0+col, y0+row), with additions in X_W+1 and Y_W+1 bits.
  - If `cnt_result != idx`, set `seq_err`.
  - Advance idx. Advance col; on col==w-1, col←0 and row←row+1.
- Clipping: a pixel whose sum is ≥ SCREEN_W or ≥ SCREEN_H produces `vga_plot=0`, but the walker still advances.
- RUN exit:
  - `cnt_counting=0` on the first RUN cycle (counter never responded) → set `seq_err`, → DONE.
  - `cnt_counting=0` on any later cycle → DONE.
  - idx reaching limit while `cnt_counting` is still 1 → set `seq_err`, stop plotting, wait for `cnt_counting=0`.
- DONE: `done=1` for one cycle. → IDLE.
- `req_valid` is ignored outside IDLE.

## Timing
- Reset values: state IDLE. `req_ready=1` (subject to `cnt_counting`). `cnt_start=0`, `cnt_limit=0`. `vga_x=0`, `vga_y=0`, `vga_colour=0`, `vga_plot=0`. `done=0`, `seq_err=0`.
- Counter contract, for start at cycle S:
  - `cnt_counting` rises at S+1.
  - `cnt_result` is 0..N-1, one value per cycle, during S+1..S+N.
  - `cnt_counting` falls at S+N+1.
- Accept at cycle T, N=w*h>0:
  - `cnt_start` high at T+1.
  - Walker samples T+2..T+1+N.
  - `vga_*` registered: `vga_plot` valid T+3..T+2+N.
  - `done` at T+3+N. `req_ready` high again at T+4+N.
- Zero-area accept at T: `done` at T+1. No `cnt_start`, no plot.
- Throughput: one pixel per clock. Back-to-back requests separated only by the DONE and IDLE cycles.
- Async reset mid-RUN: outputs clear immediately. The counter is not reset. The engine waits in IDLE with `req_ready=0` until `cnt_counting` falls.

## Structure
- Package `fill_pkg`: X_W/Y_W/COLOR_W/CNT_W defaults, SCREEN_W/SCREEN_H, and the state enum (IDLE, START, RUN, DONE).
- Sub-module `raster_walker`: holds col/row/idx counters with clear and advance inputs, w as a bound, and outputs col, row, idx, last. The FSM and output registers stay in `rect_fill_engine`.
- The bench instantiates the real counter as the slave.

## Test plan
- Request (10,20,4,3,colour 5) → `cnt_limit=12`. 12 plots in raster order: (10,20)..(13,20), (10,21).., (13,22). `done` at T+15. `seq_err=0`.
- Request (158,118,4,4,2) → 16 indices consumed. Plots only at x∈{158,159}, y∈{118,119} (4 pixels). `done` at T+19.
- Request with w=0, h=7 → `done` at T+1. `cnt_start` never asserted. `vga_plot` never asserted.
- Counter replaced by a stub that never raises `cnt_counting` → `seq_err=1` and `done` at T+3. Next accept clears `seq_err`.
- Stub returns `cnt_result` skipping index 5 in a 3x3 fill → `seq_err=1`, all 9 plot cycles still emitted.
- Assert `resetn` low at the 4th RUN cycle of an 8x8 fill → outputs zero immediately. `req_ready` stays 0 until the counter's `cnt_counting` falls, then a new 1x1 request completes with 1 plot.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared widths, screen bounds and FSM encoding for the rectangle-fill engine.
package fill_pkg;

  localparam int unsigned DEF_X_W      = 8;
  localparam int unsigned DEF_Y_W      = 7;
  localparam int unsigned DEF_COLOR_W  = 3;
  localparam int unsigned DEF_CNT_W    = 17;
  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/raster_walker.sv
// Column/row/index walker for a rectangle. Column wraps at w-1 and bumps the row.
module raster_walker
  import fill_pkg::*;
#(
  parameter int unsigned X_W   = DEF_X_W,
  parameter int unsigned Y_W   = DEF_Y_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             advance,
  input  logic [X_W-1:0]   w,
  output logic [X_W-1:0]   col,
  output logic [Y_W-1:0]   row,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  assign last = (col == w - X_W'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col <= '0;
      row <= '0;
      idx <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
      idx <= '0;
    end else if (advance) begin
      idx <= idx + CNT_W'(1);
      if (last) begin
        col <= '0;
        row <= row + Y_W'(1);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle-fill initiator: starts the external index counter and turns each
// streamed index into a clipped, registered VGA plot write.
module rect_fill_engine
  import fill_pkg::*;
#(
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned COLOR_W  = DEF_COLOR_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_W-1:0]     req_x0,
  input  logic [Y_W-1:0]     req_y0,
  input  logic [X_W-1:0]     req_w,
  input  logic [Y_W-1:0]     req_h,
  input  logic [COLOR_W-1:0] req_color,
  output logic               cnt_start,
  output logic [CNT_W-1:0]   cnt_limit,
  input  logic               cnt_counting,
  input  logic [CNT_W-1:0]   cnt_result,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot,
  output logic               done,
  output logic               seq_err
);

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t state_q, state_d;

  logic [X_W-1:0]     x0_q, w_q;
  logic [Y_W-1:0]     y0_q, h_q;
  logic [COLOR_W-1:0] color_q;
  logic               full_q;

  logic [X_W-1:0]   col;
  logic [Y_W-1:0]   row;
  logic [CNT_W-1:0] idx;
  logic             walk_last;

  logic accept, walk_clear, walk_adv, emit, err_set;
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  logic in_screen;

  assign req_ready = (state_q == IDLE) & ~cnt_counting;
  assign accept    = req_valid & req_ready;
  assign sum_x     = {1'b0, x0_q} + {1'b0, col};
  assign sum_y     = {1'b0, y0_q} + {1'b0, row};
  assign in_screen = (sum_x < SCR_W) && (sum_y < SCR_H);

  raster_walker #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .CNT_W (CNT_W)
  ) u_walker (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (walk_clear),
    .advance (walk_adv),
    .w       (w_q),
    .col     (col),
    .row     (row),
    .idx     (idx),
    .last    (walk_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    walk_clear = 1'b0;
    walk_adv   = 1'b0;
    emit       = 1'b0;
    err_set    = 1'b0;
    cnt_start  = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_w == '0 || req_h == '0) state_d = DONE;
          else                            state_d = START;
        end
      end
      START: begin
        cnt_start  = 1'b1;
        walk_clear = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (!cnt_counting) begin
          // idx still zero means the counter never produced a single index
          if (idx == '0) err_set = 1'b1;
          state_d = DONE;
        end else if (full_q) begin
          err_set = 1'b1;
        end else begin
          emit     = 1'b1;
          walk_adv = 1'b1;
          if (cnt_result != idx) err_set = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      cnt_limit  <= '0;
      seq_err    <= 1'b0;
      full_q     <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      if (accept) begin
        x0_q      <= req_x0;
        y0_q      <= req_y0;
        w_q       <= req_w;
        h_q       <= req_h;
        color_q   <= req_color;
        cnt_limit <= CNT_W'(req_w) * CNT_W'(req_h);
        seq_err   <= 1'b0;
      end else if (err_set) begin
        seq_err <= 1'b1;
      end
      // Walking off the last column of the last row is exactly idx reaching w*h
      if (walk_clear)
        full_q <= 1'b0;
      else if (walk_adv && walk_last && row == h_q - Y_W'(1))
        full_q <= 1'b1;
      vga_plot <= emit & in_screen;
      if (emit) begin
        vga_x      <= sum_x[X_W-1:0];
        vga_y      <= sum_y[Y_W-1:0];
        vga_colour <= color_q;
      end
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine with a behavioural index counter slave.
module tb_rect_fill_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_x0, req_w;
  logic [6:0]  req_y0, req_h;
  logic [2:0]  req_color;
  logic        cnt_start;
  logic [16:0] cnt_limit;
  logic        cnt_counting;
  logic [16:0] cnt_result;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        done;
  logic        seq_err;

  always #5 clk = ~clk;

  rect_fill_engine dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x0       (req_x0),
    .req_y0       (req_y0),
    .req_w        (req_w),
    .req_h        (req_h),
    .req_color    (req_color),
    .cnt_start    (cnt_start),
    .cnt_limit    (cnt_limit),
    .cnt_counting (cnt_counting),
    .cnt_result   (cnt_result),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .done         (done),
    .seq_err      (seq_err)
  );

  // Counter slave: mode 0 real, mode 1 never responds, mode 2 skips index 5.
  int          mode = 0;
  logic        cnt_on = 1'b0;
  logic [16:0] cnt_q = '0;
  logic [16:0] cnt_n = '0;

  always @(posedge clk) begin
    if (cnt_start && mode != 1) begin
      cnt_on <= 1'b1;
      cnt_q  <= '0;
      cnt_n  <= cnt_limit;
    end else if (cnt_on) begin
      if (cnt_q == cnt_n - 17'd1) cnt_on <= 1'b0;
      else                        cnt_q  <= cnt_q + 17'd1;
    end
  end

  assign cnt_counting = (mode == 1) ? 1'b0 : cnt_on;
  assign cnt_result   = (mode == 2 && cnt_q >= 17'd5) ? cnt_q + 17'd1 : cnt_q;

  // Monitor, sampling on the falling edge.
  int cyc = 0;
  int acc_cyc, done_cyc, first_plot_cyc, last_plot_cyc;
  int plots, starts;
  bit done_seen;
  logic [17:0] plot_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (req_valid && req_ready) acc_cyc = cyc;
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    if (cnt_start) starts = starts + 1;
    if (vga_plot) begin
      if (plots == 0) first_plot_cyc = cyc;
      last_plot_cyc = cyc;
      plots = plots + 1;
      plot_q.push_back({vga_x, vga_y, vga_colour});
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_fill(input int x0, input int y0, input int w, input int h,
                          input int c, output int lat);
    int k;
    plot_q.delete();
    plots = 0; starts = 0; done_seen = 1'b0;
    req_x0 = 8'(x0); req_y0 = 7'(y0); req_w = 8'(w); req_h = 7'(h);
    req_color = 3'(c);
    req_valid = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    chk("accepted", int'(k < 300), 1);
    for (k = 0; k < 500; k++) begin
      if (done_seen) break;
      @(posedge clk); #2;
    end
    chk("done_seen", int'(done_seen), 1);
    lat = done_cyc - acc_cyc;
  endtask

  typedef struct {
    int x0, y0, w, h, c;
    int exp_limit, exp_plots, exp_lat, exp_starts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, bad, mism, busy_low;
    logic [17:0] exp_q[$];

    vecs[0] = '{x0:10,  y0:20,  w:4,  h:3, c:5, exp_limit:12, exp_plots:12, exp_lat:15, exp_starts:1};
    vecs[1] = '{x0:158, y0:118, w:4,  h:4, c:2, exp_limit:16, exp_plots:4,  exp_lat:19, exp_starts:1};
    vecs[2] = '{x0:0,   y0:0,   w:0,  h:7, c:1, exp_limit:0,  exp_plots:0,  exp_lat:1,  exp_starts:0};
    vecs[3] = '{x0:5,   y0:5,   w:1,  h:1, c:7, exp_limit:1,  exp_plots:1,  exp_lat:4,  exp_starts:1};
    vecs[4] = '{x0:150, y0:0,   w:20, h:2, c:3, exp_limit:40, exp_plots:20, exp_lat:43, exp_starts:1};
    vecs[5] = '{x0:0,   y0:0,   w:5,  h:0, c:4, exp_limit:0,  exp_plots:0,  exp_lat:1,  exp_starts:0};

    resetn = 1'b0; req_valid = 1'b0;
    req_x0 = '0; req_y0 = '0; req_w = '0; req_h = '0; req_color = '0;
    plots = 0; starts = 0; done_seen = 1'b0;
    acc_cyc = 0; done_cyc = 0; first_plot_cyc = 0; last_plot_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_cnt_start", int'(cnt_start), 0);
    chk("rst_cnt_limit", int'(cnt_limit), 0);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_vga_colour", int'(vga_colour), 0);
    chk("rst_vga_plot", int'(vga_plot), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].c, lat);
      chk($sformatf("v%0d_limit", i), int'(cnt_limit), vecs[i].exp_limit);
      chk($sformatf("v%0d_plots", i), plots, vecs[i].exp_plots);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_starts", i), starts, vecs[i].exp_starts);
      chk($sformatf("v%0d_seq_err", i), int'(seq_err), 0);
      exp_q.delete();
      for (int p = 0; p < vecs[i].w * vecs[i].h; p++) begin
        int px, py;
        px = vecs[i].x0 + p % vecs[i].w;
        py = vecs[i].y0 + p / vecs[i].w;
        if (px < 160 && py < 120) exp_q.push_back({8'(px), 7'(py), 3'(vecs[i].c)});
      end
      mism = (exp_q.size() == plot_q.size()) ? 0 : 1000;
      for (int p = 0; p < exp_q.size() && p < plot_q.size(); p++)
        if (exp_q[p] != plot_q[p]) mism = mism + 1;
      chk($sformatf("v%0d_order", i), mism, 0);
      if (i == 0) begin
        chk("v0_first_plot", first_plot_cyc - acc_cyc, 3);
        chk("v0_last_plot", last_plot_cyc - acc_cyc, 14);
      end
    end

    // Counter that never answers
    mode = 1;
    run_fill(1, 1, 2, 2, 1, lat);
    chk("stub_latency", lat, 3);
    chk("stub_seq_err", int'(seq_err), 1);
    chk("stub_plots", plots, 0);
    mode = 0;
    run_fill(0, 0, 1, 1, 6, lat);
    chk("clear_seq_err", int'(seq_err), 0);
    chk("clear_plots", plots, 1);

    // Counter that skips index 5
    mode = 2;
    run_fill(20, 30, 3, 3, 4, lat);
    chk("skip_seq_err", int'(seq_err), 1);
    chk("skip_plots", plots, 9);
    chk("skip_latency", lat, 12);
    mode = 0;

    // Reset during the 4th RUN cycle of an 8x8 fill
    plots = 0;
    req_x0 = 8'd0; req_y0 = 7'd0; req_w = 8'd8; req_h = 7'd8; req_color = 3'd1;
    req_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_plot", int'(vga_plot), 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", int'(vga_plot), 0);
    chk("mid_rst_xy", int'({vga_x, vga_y, vga_colour}), 0);
    chk("mid_rst_limit", int'(cnt_limit), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    @(posedge clk); #1 resetn = 1'b1;
    busy_low = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready != !cnt_counting) bad = bad + 1;
      if (!req_ready) busy_low = busy_low + 1;
      if (!cnt_counting) break;
    end
    chk("post_rst_ready_tracks", bad, 0);
    chk("post_rst_ready_low", int'(busy_low > 0), 1);
    chk("post_rst_cnt_fell", int'(cnt_counting), 0);
    chk("post_rst_ready_high", int'(req_ready), 1);
    @(posedge clk); #1;
    run_fill(3, 4, 1, 1, 2, lat);
    chk("post_rst_plots", plots, 1);
    chk("post_rst_latency", lat, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
